// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
//   div_mode_t  : output waveform style of a divider channel
//   chan_idx_w  : width of a channel-select field for a given channel count (min 1)
package clk_div_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,  // 50 % duty, period 2*div
    MODE_PULSE  = 1'b1   // one-cycle high pulse every div cycles
  } div_mode_t;

  function automatic int unsigned chan_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_channel.sv
// One divider channel: counter, active and shadow settings, terminal-count and apply logic.
//   clk_i      : system clock
//   rst_ni     : asynchronous active-low reset
//   en_i       : count enable; low freezes counter and clk_out, forces tick low
//   sync_i     : restart at counter 0 with outputs low, applying any pending update
//   xfer_i     : accepted configuration transfer for this channel (only while not pending)
//   cfg_div_i  : divisor to shadow on transfer (0 disables the channel)
//   cfg_mode_i : mode to shadow on transfer
//   pending_o  : shadow holds an update not yet applied
//   clk_out_o  : divided output (registered)
//   tick_o     : one-cycle terminal-count strobe (registered)
module div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned Width      = 26,
  parameter int unsigned DivDefault = 25000000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             xfer_i,
  input  logic [Width-1:0] cfg_div_i,
  input  div_mode_t        cfg_mode_i,
  output logic             pending_o,
  output logic             clk_out_o,
  output logic             tick_o
);

  logic [Width-1:0] cnt_q, cnt_d;
  logic [Width-1:0] div_q, div_d;
  logic [Width-1:0] sdiv_q, sdiv_d;
  div_mode_t        mode_q, mode_d;
  div_mode_t        smode_q, smode_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  logic             disabled;
  logic             tc;
  logic             apply;
  logic [Width-1:0] eff_div;
  div_mode_t        eff_mode;

  assign disabled = (div_q == '0);
  // div is never 0 here, so div-1 cannot wrap.
  assign tc       = en_i && !disabled && (cnt_q == div_q - Width'(1));
  // A disabled channel has no TC to wait for, so it takes the update straight away, even
  // with en low.
  assign apply    = pend_q && (sync_i || tc || disabled);

  // Settings in force after this edge.
  assign eff_div  = apply ? sdiv_q : div_q;
  assign eff_mode = apply ? smode_q : mode_q;

  // Configuration path: shadow load on transfer, active load on apply. The top only raises
  // xfer_i while pend_q is low, so a transfer and an apply never collide.
  always_comb begin
    div_d   = eff_div;
    mode_d  = eff_mode;
    sdiv_d  = sdiv_q;
    smode_d = smode_q;
    pend_d  = pend_q;
    if (apply) begin
      pend_d = 1'b0;
    end
    if (xfer_i) begin
      sdiv_d  = cfg_div_i;
      smode_d = cfg_mode_i;
      pend_d  = 1'b1;
    end
  end

  // Counter and output path.
  always_comb begin
    cnt_d  = cnt_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    if (sync_i || disabled) begin
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (!en_i) begin
      // frozen: counter and clk_out hold
    end else if (tc) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      if (eff_mode == MODE_TOGGLE && eff_div != '0) begin
        // Toggle keeps running from its present level, even across a reconfiguration.
        clk_d = ~clk_q;
      end else begin
        // Unchanged pulse channel fires; a freshly applied pulse or disable starts low so
        // no runt pulse leaks out at the boundary.
        clk_d = (mode_q == MODE_PULSE) && !apply;
      end
    end else begin
      cnt_d = cnt_q + Width'(1);
      if (mode_q == MODE_PULSE) begin
        clk_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      div_q   <= Width'(DivDefault);
      mode_q  <= MODE_TOGGLE;
      sdiv_q  <= '0;
      smode_q <= MODE_TOGGLE;
      pend_q  <= 1'b0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      mode_q  <= mode_d;
      sdiv_q  <= sdiv_d;
      smode_q <= smode_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  assign pending_o = pend_q;
  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock/tick divider with glitch-free reconfiguration.
//   clk_in    : system clock
//   rst       : asynchronous active-low reset
//   en        : global count enable
//   sync      : single-cycle restart of all channels, phase-aligned at counter 0
//   cfg_valid : configuration request
//   cfg_ready : addressed channel can accept a request (1 for out-of-range channels)
//   cfg_chan  : target channel
//   cfg_div   : new divisor, 0 disables the channel
//   cfg_mode  : 0 toggle, 1 pulse
//   clk_out   : per-channel divided outputs
//   tick      : per-channel terminal-count strobes
module prog_clock_divider
  import clk_div_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned WIDTH       = 26,
  parameter int unsigned DIV_DEFAULT = 25000000
) (
  input  logic                              clk_in,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              sync,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic [chan_idx_w(CHANNELS)-1:0]   cfg_chan,
  input  logic [WIDTH-1:0]                  cfg_div,
  input  logic                              cfg_mode,
  output logic [CHANNELS-1:0]               clk_out,
  output logic [CHANNELS-1:0]               tick
);

  localparam int unsigned ChanW    = chan_idx_w(CHANNELS);
  localparam int unsigned ChanSpan = 2 ** ChanW;

  logic [CHANNELS-1:0] pending;
  logic [ChanSpan-1:0] pend_ext;
  logic                xfer_req;

  // Pad the pending vector to the full index range so an out-of-range cfg_chan reads as
  // not pending (ready) and never matches a channel below.
  always_comb begin
    pend_ext                 = '0;
    pend_ext[CHANNELS-1:0]   = pending;
  end

  assign cfg_ready = ~pend_ext[cfg_chan];
  assign xfer_req  = cfg_valid && cfg_ready;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    div_channel #(
      .Width      (WIDTH),
      .DivDefault (DIV_DEFAULT)
    ) u_chan (
      .clk_i      (clk_in),
      .rst_ni     (rst),
      .en_i       (en),
      .sync_i     (sync),
      .xfer_i     (xfer_req && (cfg_chan == ChanW'(i))),
      .cfg_div_i  (cfg_div),
      .cfg_mode_i (div_mode_t'(cfg_mode)),
      .pending_o  (pending[i]),
      .clk_out_o  (clk_out[i]),
      .tick_o     (tick[i])
    );
  end

endmodule
